// File: rtl/encoder_velocity_pkg.sv
// -----------------------------------------------------------------------------
// encoder_velocity_pkg
// Shared definitions for the dual-channel encoder velocity estimator:
//   - ST_IDLE / ST_FILL / ST_RUN : window state encoding shared by both channels
//   - vel_width()                : width of the sign-extended moving sum
// -----------------------------------------------------------------------------
package encoder_velocity_pkg;

    // IDLE : windowing disabled (en=0); the interrupted state is kept aside.
    // FILL : fewer than 2^AVG_LOG2 deltas accumulated since reset/clr.
    // RUN  : history full, the moving sum covers a complete set of windows.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // The sum of 2^avg_log2 deltas, each within a signed count_width range,
    // always fits in count_width + avg_log2 signed bits.
    function automatic int vel_width(input int count_width, input int avg_log2);
        return count_width + avg_log2;
    endfunction

endpackage

// File: rtl/encoder_velocity_ch.sv
// -----------------------------------------------------------------------------
// encoder_velocity_ch
// One velocity channel: base register, per-window delta, history shift
// register of 2^AVG_LOG2 signed deltas and the running moving sum.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   load_base  rebaseline: base <= q (clr or first cycle after reset)
//   capture    window tick: delta <= q - base, base <= q
//   update     cycle after the tick: push delta, retire oldest, update sum
//   wipe       clear history and sum
//   q          free-running count, wraps modulo 2^COUNT_WIDTH
//   vel        signed moving sum of the last 2^AVG_LOG2 deltas
// -----------------------------------------------------------------------------
module encoder_velocity_ch
    import encoder_velocity_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int AVG_LOG2    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load_base,
    input  logic                                   capture,
    input  logic                                   update,
    input  logic                                   wipe,
    input  logic        [COUNT_WIDTH-1:0]          q,
    output logic signed [COUNT_WIDTH+AVG_LOG2-1:0] vel
);

    localparam int SUM_W = vel_width(COUNT_WIDTH, AVG_LOG2);
    localparam int DEPTH = 1 << AVG_LOG2;

    logic        [COUNT_WIDTH-1:0] base;
    logic signed [COUNT_WIDTH-1:0] delta;
    logic signed [COUNT_WIDTH-1:0] hist [DEPTH];
    logic signed [SUM_W-1:0]       sum;
    logic signed [SUM_W-1:0]       delta_ext;
    logic signed [SUM_W-1:0]       oldest_ext;

    // Size casts of signed operands sign-extend into the wider sum.
    assign delta_ext  = SUM_W'(delta);
    assign oldest_ext = SUM_W'(hist[DEPTH-1]);
    assign vel        = sum;

    // The modulo subtraction read as two's complement recovers the true
    // per-window change across a counter wrap (0xFFFE -> 0x0003 gives +5).
    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge values; blocking = here would make the result order-dependent.
    always_ff @(posedge clk) begin
        if (rst) begin
            base  <= '0;
            delta <= '0;
        end else begin
            if (load_base || capture) begin
                base <= q;
            end
            if (capture) begin
                delta <= q - base;
            end
        end
    end

    // NOTE: the history is a handful of flops, not a RAM, so it is reset and
    // wiped explicitly; FILL relies on empty slots reading as zero.
    always_ff @(posedge clk) begin
        if (rst || wipe) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum <= '0;
        end else if (update) begin
            hist[0] <= delta;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            sum <= sum + delta_ext - oldest_ext;
        end
    end

endmodule

// File: rtl/encoder_velocity.sv
// -----------------------------------------------------------------------------
// encoder_velocity
// Dual-channel velocity estimator. Every WINDOW_CYCLES enabled cycles both
// encoder counts are sampled, the signed wrap-safe delta against the previous
// sample is formed, and a moving sum over the last 2^AVG_LOG2 windows is
// presented with a one-cycle valid strobe.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         windowing enable; 0 freezes timer, history and outputs
//   clr        flush history, rebaseline to current Q, restart window
//   Q0, Q1     free-running channel counts
//   vel0, vel1 signed moving sums (undivided)
//   vel_valid  one-cycle pulse when vel0/vel1 are updated
//   primed     high once 2^AVG_LOG2 windows have accumulated since reset/clr
//
// Pipeline: tick cycle T captures the delta, T+1 updates history/sum/state,
// vel and vel_valid are visible in T+2.
// -----------------------------------------------------------------------------
module encoder_velocity
    import encoder_velocity_pkg::*;
#(
    parameter int COUNT_WIDTH   = 16,
    parameter int WINDOW_CYCLES = 100000,
    parameter int AVG_LOG2      = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   clr,
    input  logic        [COUNT_WIDTH-1:0]          Q0,
    input  logic        [COUNT_WIDTH-1:0]          Q1,
    output logic signed [COUNT_WIDTH+AVG_LOG2-1:0] vel0,
    output logic signed [COUNT_WIDTH+AVG_LOG2-1:0] vel1,
    output logic                                   vel_valid,
    output logic                                   primed
);

    localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int DEPTH   = 1 << AVG_LOG2;
    localparam int FILL_W  = AVG_LOG2 + 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(DEPTH - 1);

    logic [TIMER_W-1:0] timer;
    logic               init_pending;
    logic               clr_eff;
    logic               tick;
    logic               tick_d1;
    logic               wipe;
    logic               wipe_pending;
    logic [1:0]         state;
    logic [1:0]         resume_state;
    logic [1:0]         active_state;
    logic [1:0]         next_active;
    logic [FILL_W-1:0]  fill_cnt;

    // The first cycle after reset behaves exactly like clr: rebaseline and
    // hold the timer, so the first full window starts one cycle later.
    assign clr_eff = clr | init_pending;
    assign tick    = en & ~clr_eff & (timer == TIMER_LAST);

    // A clear that lands on the in-flight update cycle lets the update finish
    // and is replayed one cycle later.
    assign wipe = (clr_eff & ~tick_d1) | wipe_pending;

    always_ff @(posedge clk) begin
        if (rst || clr_eff) begin
            timer <= '0;
        end else if (en) begin
            timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_pending <= 1'b1;
            tick_d1      <= 1'b0;
            wipe_pending <= 1'b0;
            vel_valid    <= 1'b0;
        end else begin
            init_pending <= 1'b0;
            tick_d1      <= tick;
            wipe_pending <= clr_eff & tick_d1;
            vel_valid    <= tick_d1;
        end
    end

    // IDLE only parks the machine; the logical state lives in resume_state.
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        active_state = (state == ST_IDLE) ? resume_state : state;
        next_active  = active_state;
        if (wipe) begin
            next_active = ST_FILL;
        end else if (tick_d1 && (fill_cnt == FILL_LAST)) begin
            next_active = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            resume_state <= ST_FILL;
            fill_cnt     <= '0;
            primed       <= 1'b0;
        end else begin
            resume_state <= next_active;
            state        <= (en || clr_eff) ? next_active : ST_IDLE;
            primed       <= (next_active == ST_RUN);
            if (wipe) begin
                fill_cnt <= '0;
            end else if (tick_d1 && (fill_cnt != FILL_FULL)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    encoder_velocity_ch #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .AVG_LOG2    (AVG_LOG2)
    ) u_ch0 (
        .clk       (clk),
        .rst       (rst),
        .load_base (clr_eff),
        .capture   (tick),
        .update    (tick_d1),
        .wipe      (wipe),
        .q         (Q0),
        .vel       (vel0)
    );

    encoder_velocity_ch #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .AVG_LOG2    (AVG_LOG2)
    ) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .load_base (clr_eff),
        .capture   (tick),
        .update    (tick_d1),
        .wipe      (wipe),
        .q         (Q1),
        .vel       (vel1)
    );

endmodule

// File: tb/tb_encoder_velocity.sv
// -----------------------------------------------------------------------------
// tb_encoder_velocity
// Self-checking bench for encoder_velocity (WINDOW_CYCLES=10, AVG_LOG2=2,
// COUNT_WIDTH=16). A reference model built on window counting and a queue of
// past deltas predicts outputs every cycle; scenario tasks add fixed-value
// checks.
// -----------------------------------------------------------------------------
module tb_encoder_velocity;

    localparam int CW    = 16;
    localparam int WIN   = 10;
    localparam int AL    = 2;
    localparam int VW    = CW + AL;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] q0  = '0;
    logic [CW-1:0] q1  = '0;
    logic signed [VW-1:0] vel0;
    logic signed [VW-1:0] vel1;
    logic          vel_valid;
    logic          primed;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    // Reference model state
    int            m_cnt;
    logic [CW-1:0] m_base0, m_base1;
    bit            m_pend, m_init, m_wipe_next;
    int            m_pd0, m_pd1;
    int            m_h0[$];
    int            m_h1[$];
    int            m_pushes;
    int            m_vel0, m_vel1;
    bit            m_valid, m_primed;

    encoder_velocity #(
        .COUNT_WIDTH   (CW),
        .WINDOW_CYCLES (WIN),
        .AVG_LOG2      (AL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .Q0        (q0),
        .Q1        (q1),
        .vel0      (vel0),
        .vel1      (vel1),
        .vel_valid (vel_valid),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sum_q(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_wipe();
        m_h0.delete();
        m_h1.delete();
        m_pushes = 0;
        m_vel0   = 0;
        m_vel1   = 0;
        m_primed = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs seen at that edge.
    // A window is WIN enabled, non-clear cycles; its last cycle samples Q.
    // The result appears two edges after the sampling edge.
    task automatic model_edge();
        logic [CW-1:0] d0, d1;
        bit clr_eff, had;
        if (rst) begin
            model_wipe();
            m_cnt = 0; m_pend = 0; m_valid = 0; m_init = 1; m_wipe_next = 0;
            m_base0 = '0; m_base1 = '0;
            return;
        end
        clr_eff = clr || m_init;
        m_init  = 0;
        had     = m_pend;
        m_valid = m_pend;
        m_pend  = 0;
        if (had) begin
            m_h0.push_back(m_pd0);
            m_h1.push_back(m_pd1);
            if (m_h0.size() > DEPTH) begin
                void'(m_h0.pop_front());
                void'(m_h1.pop_front());
            end
            m_vel0 = sum_q(m_h0);
            m_vel1 = sum_q(m_h1);
            m_pushes++;
            m_primed = (m_pushes >= DEPTH);
        end
        if (m_wipe_next) model_wipe();
        m_wipe_next = 0;
        if (clr_eff) begin
            if (had) m_wipe_next = 1;
            else     model_wipe();
            m_cnt = 0;
            m_base0 = q0;
            m_base1 = q1;
        end else if (en) begin
            m_cnt++;
            if (m_cnt == WIN) begin
                d0 = q0 - m_base0;
                d1 = q1 - m_base1;
                m_pd0 = int'($signed(d0));
                m_pd1 = int'($signed(d1));
                m_base0 = q0;
                m_base1 = q1;
                m_pend = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic cyc(input bit e, input bit c);
        en  = e;
        clr = c;
        @(posedge clk);
        #1;
        cyc_no++;
        model_edge();
    endtask

    function automatic bit dut_matches();
        return (vel_valid === m_valid) && (primed === m_primed) &&
               (vel0 === VW'(m_vel0)) && (vel1 === VW'(m_vel1));
    endfunction

    task automatic show(input string name);
        $display("FAIL %s cyc=%0d: got valid=%b primed=%b vel0=%0d vel1=%0d, want valid=%b primed=%b vel0=%0d vel1=%0d",
                 name, cyc_no, vel_valid, primed, vel0, vel1, m_valid, m_primed, m_vel0, m_vel1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        q0 = 16'($urandom);
        q1 = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("reset_model"); end
        end
        n_checks++;
        if ({vel_valid, primed, vel0, vel1} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got valid=%b primed=%b vel0=%0d vel1=%0d, want all 0",
                     vel_valid, primed, vel0, vel1);
        end
        rst = 1'b0;
    endtask

    task automatic test_constant_rate();
        int j = 0, nvalid = 0, last = 0;
        q0 = 16'($urandom);
        q1 = 16'($urandom);
        cyc(1, 1);
        n_checks++;
        if (!dut_matches()) begin n_fail++; show("const_clr"); end
        for (int k = 0; k < 6 * WIN + 2; k++) begin
            if (k < 6 * WIN && (k % WIN) == 0) j = $urandom_range(0, WIN - 1);
            if (k < 6 * WIN && (k % WIN) == j) q0 = q0 + 16'd3;
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("const_model"); end
            if (vel_valid) begin
                nvalid++;
                if (nvalid > 1) begin
                    n_checks++;
                    if (cyc_no - last !== WIN) begin
                        n_fail++;
                        $display("FAIL const_period: got %0d cycles, want %0d", cyc_no - last, WIN);
                    end
                end
                last = cyc_no;
                n_checks++;
                if (int'(vel0) !== 3 * ((nvalid < 4) ? nvalid : 4) || vel1 !== '0 ||
                    primed !== (nvalid >= 4)) begin
                    n_fail++;
                    $display("FAIL const_value n=%0d: got vel0=%0d vel1=%0d primed=%b, want vel0=%0d vel1=0 primed=%b",
                             nvalid, vel0, vel1, primed, 3 * ((nvalid < 4) ? nvalid : 4), nvalid >= 4);
                end
            end
        end
        n_checks++;
        if (nvalid !== 6) begin
            n_fail++;
            $display("FAIL const_count: got %0d strobes, want 6", nvalid);
        end
    endtask

    task automatic wrap_window(input logic [CW-1:0] from_q, input logic [CW-1:0] to_q,
                               input int want, input string name);
        int j, got, seen;
        j = $urandom_range(0, WIN - 1);
        got = 0;
        seen = 0;
        q0 = from_q;
        cyc(1, 1);
        n_checks++;
        if (!dut_matches()) begin n_fail++; show(name); end
        for (int k = 0; k < WIN + 2; k++) begin
            if (k == j) q0 = to_q;
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show(name); end
            if (vel_valid) begin seen++; got = int'(vel0); end
        end
        n_checks++;
        if (seen !== 1 || got !== want) begin
            n_fail++;
            $display("FAIL %s: got vel0=%0d strobes=%0d, want vel0=%0d strobes=1", name, got, seen, want);
        end
    endtask

    task automatic test_wrap();
        q1 = 16'($urandom);
        wrap_window(16'hFFFA, 16'h0004, 10, "wrap_up");
        wrap_window(16'h0004, 16'hFFFA, -10, "wrap_down");
    endtask

    task automatic test_fill_ramp();
        int j = 0, nvalid = 0;
        cyc(1, 1);
        n_checks++;
        if (!dut_matches()) begin n_fail++; show("fill_clr"); end
        for (int k = 0; k < 5 * WIN + 2; k++) begin
            if (k < 5 * WIN && (k % WIN) == 0) j = $urandom_range(0, WIN - 1);
            if (k < 5 * WIN && (k % WIN) == j) begin
                q0 = q0 + 16'd5;
                q1 = q1 + 16'($urandom_range(0, 1000) - 500);
            end
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("fill_model"); end
            if (vel_valid) begin
                nvalid++;
                n_checks++;
                if (int'(vel0) !== 5 * ((nvalid < 4) ? nvalid : 4) || primed !== (nvalid >= 4)) begin
                    n_fail++;
                    $display("FAIL fill_value n=%0d: got vel0=%0d primed=%b, want vel0=%0d primed=%b",
                             nvalid, vel0, primed, 5 * ((nvalid < 4) ? nvalid : 4), nvalid >= 4);
                end
            end
        end
        n_checks++;
        if (nvalid !== 5) begin
            n_fail++;
            $display("FAIL fill_count: got %0d strobes, want 5", nvalid);
        end
    endtask

    task automatic test_clear_upstream();
        int j = 0, nvalid = 0;
        q0 = 16'd1000;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("clrup_pre"); end
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 1) q0 = 16'd0;
            cyc(1, 1);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("clrup_hold"); end
        end
        n_checks++;
        if (vel0 !== '0 || primed !== 1'b0) begin
            n_fail++;
            $display("FAIL clrup_cleared: got vel0=%0d primed=%b, want vel0=0 primed=0", vel0, primed);
        end
        for (int k = 0; k < 4 * WIN + 2; k++) begin
            if (k < 4 * WIN && (k % WIN) == 0) j = $urandom_range(0, WIN - 1);
            if (k < 4 * WIN && (k % WIN) == j) q0 = q0 + 16'd2;
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("clrup_model"); end
            if (vel_valid) begin
                nvalid++;
                n_checks++;
                if (int'(vel0) !== 2 * nvalid) begin
                    n_fail++;
                    $display("FAIL clrup_value n=%0d: got vel0=%0d, want %0d", nvalid, vel0, 2 * nvalid);
                end
            end
        end
        n_checks++;
        if (nvalid !== 4 || primed !== 1'b1) begin
            n_fail++;
            $display("FAIL clrup_count: got %0d strobes primed=%b, want 4 strobes primed=1", nvalid, primed);
        end
    endtask

    task automatic test_enable_gap();
        int j, gap_valids = 0, post = 0;
        cyc(1, 1);
        n_checks++;
        if (!dut_matches()) begin n_fail++; show("gap_clr"); end
        j = $urandom_range(0, WIN - 1);
        for (int k = 0; k < WIN + 3; k++) begin
            if (k == j) q0 = q0 + 16'd4;
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("gap_first"); end
        end
        j = $urandom_range(0, 24);
        for (int k = 0; k < 25; k++) begin
            if (k == j) q0 = q0 + 16'd7;
            cyc(0, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("gap_off"); end
            if (vel_valid) gap_valids++;
        end
        n_checks++;
        if (gap_valids !== 0) begin
            n_fail++;
            $display("FAIL gap_quiet: got %0d strobes during en=0, want 0", gap_valids);
        end
        j = $urandom_range(0, 6);
        for (int k = 0; k < 9; k++) begin
            if (k == j) q0 = q0 + 16'd1;
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("gap_resume"); end
            if (vel_valid) post = int'(vel0);
        end
        n_checks++;
        if (post !== 12) begin
            n_fail++;
            $display("FAIL gap_fold: got vel0=%0d after resume, want 12", post);
        end
    endtask

    task automatic test_reset_mid();
        int first = 0, guard = 0;
        while (m_cnt != 5 && guard < 2 * WIN) begin
            cyc(1, 0);
            guard++;
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("rstmid_align"); end
        end
        rst = 1'b1;
        cyc(1, 0);
        n_checks++;
        if ({vel_valid, primed, vel0, vel1} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_zero: got valid=%b primed=%b vel0=%0d vel1=%0d, want all 0",
                     vel_valid, primed, vel0, vel1);
        end
        rst = 1'b0;
        for (int n = 1; n <= 3 * WIN && first == 0; n++) begin
            cyc(1, 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("rstmid_model"); end
            if (vel_valid) first = n;
        end
        n_checks++;
        if (first !== WIN + 2) begin
            n_fail++;
            $display("FAIL rstmid_latency: got first strobe after %0d cycles, want %0d (0 = none)",
                     first, WIN + 2);
        end
    endtask

    task automatic test_random();
        bit e = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 14) == 0) e = ~e;
            q0 = q0 + 16'($urandom_range(0, 200) - 100);
            q1 = q1 + 16'($urandom_range(0, 200) - 100);
            cyc(e, $urandom_range(0, 39) == 0);
            n_checks++;
            if (!dut_matches()) begin n_fail++; show("random"); end
        end
    endtask

    initial begin
        test_reset();
        test_constant_rate();
        test_wrap();
        test_fill_ramp();
        test_clear_upstream();
        test_enable_gap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_velocity.md
# encoder_velocity

Dual-channel velocity estimator that consumes the two free-running encoder counts produced by the pulse counter stage (Q0/Q1). Every fixed window it samples each count, forms the signed modulo difference against the previous sample, and keeps a moving sum over the last 2^AVG_LOG2 windows. Results go to the AXI register file / motor control loop with a one-cycle valid strobe.

## Interface
- COUNT_WIDTH, 16, width of the incoming counts Q0/Q1
- WINDOW_CYCLES, 100000, clk cycles per sample window (1 ms at 100 MHz); ≥ 4
- AVG_LOG2, 2, log2 of the number of windows in the moving sum (0 = no averaging)
- clk  in  1  system clock; all logic is single-clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  windowing enable; 0 freezes timer, history and outputs
- clr  in  1  flush history, rebaseline to the current Q, restart window
- Q0  in  COUNT_WIDTH  channel 0 count (wraps modulo 2^COUNT_WIDTH)
- Q1  in  COUNT_WIDTH  channel 1 count
- vel0  out  COUNT_WIDTH+AVG_LOG2  signed moving sum of channel 0 deltas
- vel1  out  COUNT_WIDTH+AVG_LOG2  signed moving sum of channel 1 deltas
- vel_valid  out  1  one-cycle pulse when vel0/vel1 are updated
- primed  out  1  high once 2^AVG_LOG2 windows have been accumulated since reset/clr

## Operation
- Window timer counts 0..WINDOW_CYCLES-1 while en=1 and clr=0; the cycle with timer = WINDOW_CYCLES-1 is the tick and the timer wraps to 0.
- On tick, per channel: delta = Q - base (COUNT_WIDTH-bit subtraction, result read as two's complement), base <= Q.
- Wrap rule: a true per-window change must lie in [-2^(COUNT_WIDTH-1), 2^(COUNT_WIDTH-1)-1]; e.g. base 0xFFFE, Q 0x0003 gives delta +5.
- History: shift register of 2^AVG_LOG2 signed deltas per channel. Sum update: sum <= sum + delta - oldest; oldest is discarded. Sign-extend to COUNT_WIDTH+AVG_LOG2; the sum cannot overflow at that width.
- vel = sum (undivided); software divides by 2^AVG_LOG2 and by the window time.
- States (shared by both channels): IDLE (en=0), FILL (fewer than 2^AVG_LOG2 deltas since reset/clr), RUN. IDLE->FILL/RUN on en=1 (resumes the previous state); FILL->RUN when the 2^AVG_LOG2-th delta is pushed; any->FILL on clr; any->IDLE on en=0, with state remembered for resume.
- In FILL, empty history slots hold 0, so vel is the partial sum; vel_valid still pulses; primed=0.
- clr: while high, base <= Q every cycle, history and sum cleared, timer held at 0, no ticks. This absorbs an upstream counter clear asserted in the same or an overlapping cycle. The first window starts the cycle after clr falls.
- en=0: timer, base and history frozen; Q changes during this time are folded into the first delta after resume.
- clr has priority over en; rst has priority over everything.

## Timing
- Reset values: vel0=0, vel1=0, vel_valid=0, primed=0, timer=0, history=0. base loads Q in the first cycle after rst falls (same handling as clr).
- Pipeline: tick cycle T captures delta; T+1 updates sum/history/state; vel and vel_valid are registered and visible in cycle T+2. vel holds until the next update.
- vel_valid period is exactly WINDOW_CYCLES cycles in steady state; it is never high for two consecutive cycles.
- primed rises in the same cycle as the vel_valid that carries the 2^AVG_LOG2-th delta.
- clr or en=0 in cycle T+1 still completes the in-flight update if the tick occurred at T (clr then wipes it in the following cycle). clr at T suppresses the tick.
- rst mid-window aborts everything; no vel_valid is emitted for a partial window.

## Structure
- Package encoder_velocity_pkg holds the state encoding (IDLE, FILL, RUN) and a function for the sign-extended delta width.
- Sub-module encoder_velocity_ch: base register, delta, history shift register, moving sum. It is instantiated twice.
- The top level owns the window timer, state machine, primed flag and vel_valid.

## Test plan
Bench parameters: WINDOW_CYCLES=10, AVG_LOG2=2, COUNT_WIDTH=16.
- Constant rate: Q0 += 3 per window, Q1 constant -> after 4 windows vel0=12, vel1=0, primed=1, vel_valid every 10 cycles.
- Wrap: Q0 steps 0xFFFA -> 0x0004 across one window -> delta +10; reverse 0x0004 -> 0xFFFA -> delta -10; check vel0 sign and value.
- Fill ramp: deltas 5,5,5,5,5 -> vel0 reads 5,10,15,20,20; primed rises with the 4th value.
- Clear with upstream reset: Q0=1000, pulse clr for 3 cycles while Q0 -> 0, then +2 per window -> no spurious delta; vel0 reads 2,4,6,8.
- Enable gap: en=0 for 25 cycles while Q0 advances by 7 -> no vel_valid during the gap; the first post-resume delta includes the +7.
- Reset mid-window: rst in timer cycle 5 -> all outputs 0 next cycle; first vel_valid occurs 10+2 cycles after rst falls.
